// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller.
// Holds the 9-cell board, accepts and validates player moves, alternates turns
// and turns the external line detectors' verdict into win / draw status.
// Cell i lives at board[2i+1:2i]: 00 empty, 01 X, 10 O.
// Optional macro TTT_MOVE_TIMEOUT_EN: forfeits the turn after TIMEOUT_CYCLES
// idle cycles while waiting for a move; without it, timeout is tied low.
module ttt_move_ctrl #(
   parameter logic [1:0] FIRST_PLAYER   = 2'b01,
   parameter int         TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_game,
   input  logic        move_valid,
   input  logic [3:0]  move_pos,
   input  logic        win_in,
   input  logic [1:0]  win_who_in,
   output logic [17:0] board,
   output logic [1:0]  turn,
   output logic        ready,
   output logic        move_ack,
   output logic        illegal,
   output logic        game_over,
   output logic [1:0]  winner_who,
   output logic        draw,
   output logic        timeout
);

   typedef enum logic [1:0] {
      S_WAIT  = 2'b00,
      S_CHECK = 2'b01,
      S_OVER  = 2'b10
   } state_t;

   state_t     state;
   logic [3:0] move_cnt;
   logic [1:0] target_cell;
   logic       move_ok;
   logic       expire;

   function automatic logic [1:0] other_player(input logic [1:0] p);
      return (p == 2'b01) ? 2'b10 : 2'b01;
   endfunction

   assign ready = (state == S_WAIT);

   // Look up the addressed cell and decide whether the requested move is legal
   always_comb begin
      target_cell = 2'b00;
      for (int i = 0; i < 9; i++) begin
         if (move_pos == 4'(i)) begin
            target_cell = board[2*i +: 2];
         end
      end
      move_ok = (move_pos <= 4'd8) && (target_cell == 2'b00);
   end

`ifdef TTT_MOVE_TIMEOUT_EN
   localparam int            TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] idle_cnt;

   // A pending move always beats expiry, so only a quiet last cycle forfeits
   assign expire = (state == S_WAIT) && !move_valid && (idle_cnt == TLAST);

   // Idle counter: runs only while waiting, saturates at its last value, pulses on expiry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         if (new_game || (state != S_WAIT) || (move_valid && move_ok)) begin
            idle_cnt <= '0;
         end else if (expire) begin
            idle_cnt <= '0;
            timeout  <= 1'b1;
         end else if (idle_cnt != TLAST) begin
            idle_cnt <= idle_cnt + TW'(1);
         end
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign expire             = 1'b0;
   assign timeout            = 1'b0;
`endif

   // Game FSM: accept/reject moves in WAIT, judge the new board in CHECK, freeze in OVER
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_WAIT;
         board      <= '0;
         turn       <= FIRST_PLAYER;
         move_cnt   <= '0;
         move_ack   <= 1'b0;
         illegal    <= 1'b0;
         game_over  <= 1'b0;
         winner_who <= 2'b00;
         draw       <= 1'b0;
      end else begin
         move_ack <= 1'b0;
         illegal  <= 1'b0;
         if (new_game) begin
            // A move in the same cycle is dropped without ack or illegal
            state      <= S_WAIT;
            board      <= '0;
            turn       <= FIRST_PLAYER;
            move_cnt   <= '0;
            game_over  <= 1'b0;
            winner_who <= 2'b00;
            draw       <= 1'b0;
         end else begin
            case (state)
               S_WAIT: begin
                  if (move_valid) begin
                     if (move_ok) begin
                        for (int i = 0; i < 9; i++) begin
                           if (move_pos == 4'(i)) begin
                              board[2*i +: 2] <= turn;
                           end
                        end
                        move_cnt <= move_cnt + 4'd1;
                        move_ack <= 1'b1;
                        state    <= S_CHECK;
                     end else begin
                        illegal <= 1'b1;
                     end
                  end else if (expire) begin
                     turn <= other_player(turn);
                  end
               end
               S_CHECK: begin
                  // Detectors now see the registered board; a win outranks a full board
                  if (win_in) begin
                     game_over  <= 1'b1;
                     winner_who <= win_who_in;
                     state      <= S_OVER;
                  end else if (move_cnt == 4'd9) begin
                     game_over <= 1'b1;
                     draw      <= 1'b1;
                     state     <= S_OVER;
                  end else begin
                     turn  <= other_player(turn);
                     state <= S_WAIT;
                  end
               end
               S_OVER: begin
                  if (move_valid) begin
                     illegal <= 1'b1;
                  end
               end
               default: state <= S_WAIT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl: directed vector table, hand-written corner sequences
// and randomized play checked against a game-level reference model.
module tb_ttt_move_ctrl;

   localparam int T = 8;
`ifdef TTT_MOVE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        new_game;
   logic        move_valid;
   logic [3:0]  move_pos;
   logic        win_in;
   logic [1:0]  win_who_in;
   logic [17:0] board;
   logic [1:0]  turn;
   logic        ready;
   logic        move_ack;
   logic        illegal;
   logic        game_over;
   logic [1:0]  winner_who;
   logic        draw;
   logic        timeout;

   int n_checks = 0;
   int n_fail   = 0;

   ttt_move_ctrl #(.FIRST_PLAYER(2'b01), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
      .move_pos(move_pos), .win_in(win_in), .win_who_in(win_who_in),
      .board(board), .turn(turn), .ready(ready), .move_ack(move_ack),
      .illegal(illegal), .game_over(game_over), .winner_who(winner_who),
      .draw(draw), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Return the player owning any complete line of the board, else 00
   function automatic logic [1:0] line_winner(input logic [17:0] b);
      int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
      logic [1:0] a, c, d;
      logic [1:0] w;
      w = 2'b00;
      for (int k = 0; k < 8; k++) begin
         a = b[2*ln[k][0] +: 2];
         c = b[2*ln[k][1] +: 2];
         d = b[2*ln[k][2] +: 2];
         if (a != 2'b00 && a == c && a == d) w = a;
      end
      return w;
   endfunction

   // External line-detector bank attached to the DUT board
   always_comb begin
      win_who_in = line_winner(board);
      win_in     = (win_who_in != 2'b00);
   end

   // Reference model state, in game terms
   logic [17:0] m_board;
   logic [1:0]  m_turn;
   int          m_count;
   bit          m_eval;
   bit          m_over;
   logic [1:0]  m_who;
   bit          m_draw;
   int          m_idle;
   bit          e_ack, e_ill, e_to;

   task automatic model_clear();
      m_board = '0; m_turn = 2'b01; m_count = 0; m_eval = 0; m_over = 0;
      m_who = 2'b00; m_draw = 0; m_idle = 0; e_ack = 0; e_ill = 0; e_to = 0;
   endtask

   task automatic model_step(input logic ng, input logic mv, input logic [3:0] pos);
      int p;
      logic [1:0] w;
      p = int'(pos);
      e_ack = 0; e_ill = 0; e_to = 0;
      if (ng) begin
         model_clear();
      end else if (m_eval) begin
         m_eval = 0;
         w = line_winner(m_board);
         if (w != 2'b00) begin
            m_over = 1; m_who = w;
         end else if (m_count == 9) begin
            m_over = 1; m_draw = 1;
         end else begin
            m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
         end
      end else if (m_over) begin
         e_ill = mv;
      end else if (mv && p <= 8 && m_board[2*p +: 2] == 2'b00) begin
         m_board[2*p +: 2] = m_turn;
         m_count++;
         e_ack  = 1;
         m_eval = 1;
         m_idle = 0;
      end else if (mv) begin
         e_ill = 1;
         if (TO_EN && m_idle < T-1) m_idle++;
      end else if (TO_EN) begin
         if (m_idle == T-1) begin
            e_to = 1;
            m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
            m_idle = 0;
         end else begin
            m_idle++;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("board", 32'(board), 32'(m_board));
      check("turn", 32'(turn), 32'(m_turn));
      check("ready", 32'(ready), 32'(!m_eval && !m_over));
      check("move_ack", 32'(move_ack), 32'(e_ack));
      check("illegal", 32'(illegal), 32'(e_ill));
      check("game_over", 32'(game_over), 32'(m_over));
      check("winner_who", 32'(winner_who), 32'(m_who));
      check("draw", 32'(draw), 32'(m_draw));
      check("timeout", 32'(timeout), 32'(e_to));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_board"}, 32'(board), 0);
      check({tag, "_turn"}, 32'(turn), 1);
      check({tag, "_ready"}, 32'(ready), 1);
      check({tag, "_ack"}, 32'(move_ack), 0);
      check({tag, "_illegal"}, 32'(illegal), 0);
      check({tag, "_over"}, 32'(game_over), 0);
      check({tag, "_who"}, 32'(winner_who), 0);
      check({tag, "_draw"}, 32'(draw), 0);
      check({tag, "_timeout"}, 32'(timeout), 0);
   endtask

   // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later
   task automatic apply(input logic ng, input logic mv, input logic [3:0] pos);
      new_game = ng; move_valid = mv; move_pos = pos;
      @(posedge clk);
      model_step(ng, mv, pos);
      #1;
      new_game = 1'b0; move_valid = 1'b0;
   endtask

   typedef struct {
      logic        ng;
      logic        mv;
      logic [3:0]  pos;
      logic [17:0] b;
      logic [1:0]  t;
      logic        rdy;
      logic        ack;
      logic        ill;
      logic        ov;
      logic [1:0]  who;
      logic        dr;
   } vec_t;

   vec_t tbl [20];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 4'd0,  18'h000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 4'd0,  18'h001, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 4'd0,  18'h001, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 4'd3,  18'h081, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 4'd0,  18'h081, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 4'd1,  18'h085, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 4'd0,  18'h085, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 4'd4,  18'h285, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 4'd0,  18'h285, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 4'd2,  18'h295, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 4'd0,  18'h295, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 4'd5,  18'h295, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 4'd0,  18'h000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 4'd9,  18'h000, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 4'd15, 18'h000, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 4'd4,  18'h100, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 4'd0,  18'h100, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[17] = '{1'b0, 1'b1, 4'd4,  18'h100, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
      tbl[18] = '{1'b0, 1'b1, 4'd0,  18'h102, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      tbl[19] = '{1'b0, 1'b1, 4'd1,  18'h102, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};

      reset = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;
      model_clear();

      // Directed vectors: X row win, OVER behaviour, out-of-range, occupied, CHECK ignore
      for (int r = 0; r < 20; r++) begin
         apply(tbl[r].ng, tbl[r].mv, tbl[r].pos);
         check($sformatf("tbl%0d_board", r), 32'(board), 32'(tbl[r].b));
         check($sformatf("tbl%0d_turn", r), 32'(turn), 32'(tbl[r].t));
         check($sformatf("tbl%0d_ready", r), 32'(ready), 32'(tbl[r].rdy));
         check($sformatf("tbl%0d_ack", r), 32'(move_ack), 32'(tbl[r].ack));
         check($sformatf("tbl%0d_illegal", r), 32'(illegal), 32'(tbl[r].ill));
         check($sformatf("tbl%0d_over", r), 32'(game_over), 32'(tbl[r].ov));
         check($sformatf("tbl%0d_who", r), 32'(winner_who), 32'(tbl[r].who));
         check($sformatf("tbl%0d_draw", r), 32'(draw), 32'(tbl[r].dr));
         check($sformatf("tbl%0d_timeout", r), 32'(timeout), 0);
      end

      // Draw game: nine moves without a line, then a rejected extra move
      begin
         int dseq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
         apply(1'b1, 1'b0, 4'd0);
         compare_model();
         for (int i = 0; i < 9; i++) begin
            apply(1'b0, 1'b1, 4'(dseq[i]));
            compare_model();
            apply(1'b0, 1'b0, 4'd0);
            compare_model();
         end
         check("draw_flag", 32'(draw), 1);
         check("draw_over", 32'(game_over), 1);
         check("draw_who", 32'(winner_who), 0);
         apply(1'b0, 1'b1, 4'd3);
         check("draw_extra_illegal", 32'(illegal), 1);
         compare_model();
      end

      // new_game coinciding with a legal move mid-game
      apply(1'b1, 1'b0, 4'd0);
      apply(1'b0, 1'b1, 4'd4);
      apply(1'b0, 1'b0, 4'd0);
      apply(1'b0, 1'b1, 4'd0);
      apply(1'b0, 1'b0, 4'd0);
      compare_model();
      apply(1'b1, 1'b1, 4'd2);
      check("restart_board", 32'(board), 0);
      check("restart_turn", 32'(turn), 1);
      check("restart_ack", 32'(move_ack), 0);
      check("restart_illegal", 32'(illegal), 0);
      compare_model();

      // Async reset while in CHECK takes effect without a clock edge
      apply(1'b0, 1'b1, 4'd4);
      check("pre_reset_ack", 32'(move_ack), 1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("async");
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();

`ifdef TTT_MOVE_TIMEOUT_EN
      // Turn forfeit after T idle cycles, then a move landing on the expiry cycle
      apply(1'b1, 1'b0, 4'd0);
      repeat (T-1) begin
         apply(1'b0, 1'b0, 4'd0);
         compare_model();
      end
      check("to_not_yet", 32'(timeout), 0);
      apply(1'b0, 1'b0, 4'd0);
      check("to_pulse", 32'(timeout), 1);
      check("to_turn", 32'(turn), 2);
      check("to_board", 32'(board), 0);
      compare_model();
      repeat (T-1) apply(1'b0, 1'b0, 4'd0);
      apply(1'b0, 1'b1, 4'd4);
      check("to_move_wins_ack", 32'(move_ack), 1);
      check("to_move_wins_to", 32'(timeout), 0);
      check("to_move_board", 32'(board), 32'h200);
      compare_model();
`else
      repeat (2*T) begin
         apply(1'b0, 1'b0, 4'd0);
         compare_model();
      end
`endif

      // Randomized play against the reference model
      apply(1'b1, 1'b0, 4'd0);
      compare_model();
      for (int c = 0; c < 800; c++) begin
         logic       ng, mv;
         logic [3:0] p;
         ng = ($urandom_range(0, 59) == 0);
         mv = ($urandom_range(0, 2) != 0);
         p  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                          : 4'($urandom_range(0, 8));
         apply(ng, mv, p);
         compare_model();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
